// File: rtl/gpio_bcd_display.sv
// Captures the CPU gpio_out value on change and converts it to BCD with a
// sequential double-dabble engine. Optional leading-zero blanking: BCD_LZ_BLANK_EN.
module gpio_bcd_display #(
    parameter int unsigned DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         value,
    output logic                busy,
    output logic                valid,
    output logic                overflow,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] hex
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state, state_n;

    logic [31:0] cap;
    logic [31:0] sh;
    logic [39:0] acc;
    logic [5:0]  cnt;
    logic        first;

    logic          start;
    logic [39:0]   acc_adj;
    logic [39:0]   acc_shift;
    logic [31:0]   sh_shift;
    logic [7*DIGITS-1:0] hex_n;
    logic          ovf_n;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign start = first || (value != cap);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CONV;
            CONV:    if (cnt == 6'd31) state_n = LOAD;
            LOAD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Add-3 is strictly per nibble; no carry crosses a digit boundary.
    always_comb begin
        acc_adj = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                acc_adj[4*i +: 4] = acc[4*i +: 4];
            end
        end
        acc_shift = {acc_adj[38:0], sh[31]};
        sh_shift  = {sh[30:0], 1'b0};
    end

    always_comb begin
`ifdef BCD_LZ_BLANK_EN
        logic        lead;
        int unsigned idx;
`endif
        hex_n = '1;
        ovf_n = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i >= DIGITS) begin
                ovf_n = ovf_n | (acc[4*i +: 4] != 4'd0);
            end
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            hex_n[7*i +: 7] = seg7(acc[4*i +: 4]);
        end
`ifdef BCD_LZ_BLANK_EN
        // Scan from the top digit down; blank zeros until the first nonzero.
        lead = !ovf_n;
        idx  = 0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            if (lead && (idx != 0) && (acc[4*idx +: 4] == 4'd0)) begin
                hex_n[7*idx +: 7] = 7'h7F;
            end else begin
                lead = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap      <= '0;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            first    <= 1'b1;
            valid    <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            hex      <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cap   <= value;
                        sh    <= value;
                        acc   <= '0;
                        cnt   <= '0;
                        first <= 1'b0;
                    end
                end
                CONV: begin
                    acc <= acc_shift;
                    sh  <= sh_shift;
                    cnt <= cnt + 6'd1;
                end
                LOAD: begin
                    bcd      <= acc[4*DIGITS-1:0];
                    hex      <= hex_n;
                    overflow <= ovf_n;
                    valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Directed self-checking bench for gpio_bcd_display with DIGITS = 8.
module tb_gpio_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value = '0;
    logic        busy;
    logic        valid;
    logic        overflow;
    logic [31:0] bcd;
    logic [55:0] hex;

    int checks = 0;
    int failures = 0;

    gpio_bcd_display #(.DIGITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow),
        .bcd      (bcd),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b required 0 within 100 cycles", name, busy);
        end
    endtask

    task automatic test_reset;
        logic [55:0] hx;
`ifdef BCD_LZ_BLANK_EN
        hx = {{7{7'h7F}}, 7'h40};
`else
        hx = {8{7'h40}};
`endif
        rst = 1'b0; value = 32'd0;
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b required 0", overflow); end
        checks++; if (bcd !== 32'h0) begin failures++; $display("FAIL rst_bcd: got %h required 0", bcd); end
        checks++; if (hex !== {56{1'b1}}) begin failures++; $display("FAIL rst_hex: got %h required all 7F", hex); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_first_busy: got %b required 1", busy); end
        repeat (32) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rst_early: valid=%b busy=%b required 0/1", valid, busy); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_done: valid=%b busy=%b required 1/0", valid, busy); end
        checks++; if (bcd !== 32'h0) begin failures++; $display("FAIL rst_zero_bcd: got %h required 0", bcd); end
        checks++; if (hex !== hx) begin failures++; $display("FAIL rst_zero_hex: got %h required %h", hex, hx); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_zero_ovf: got %b required 0", overflow); end
    endtask

    task automatic test_1234;
        logic [55:0] hx;
`ifdef BCD_LZ_BLANK_EN
        hx = {{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19};
`else
        hx = {{4{7'h40}}, 7'h79, 7'h24, 7'h30, 7'h19};
`endif
        @(negedge clk); value = 32'd1234;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c1234_busy: got %b required 1", busy); end
        repeat (32) @(posedge clk);
        #1;
        checks++; if (bcd !== 32'h0) begin failures++; $display("FAIL c1234_hold: got %h required 0 before load", bcd); end
        @(posedge clk); #1;
        checks++; if (bcd !== 32'h00001234) begin failures++; $display("FAIL c1234_bcd: got %h required 00001234", bcd); end
        checks++; if (hex !== hx) begin failures++; $display("FAIL c1234_hex: got %h required %h", hex, hx); end
    endtask

    task automatic test_overflow;
        @(negedge clk); value = 32'd99999999;
        wait_done("ovf_a");
        checks++; if (bcd !== 32'h99999999) begin failures++; $display("FAIL ovf_a_bcd: got %h required 99999999", bcd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_a_flag: got %b required 0", overflow); end
        checks++; if (hex !== {8{7'h10}}) begin failures++; $display("FAIL ovf_a_hex: got %h required all 10", hex); end
        @(negedge clk); value = 32'd100000000;
        wait_done("ovf_b");
        checks++; if (bcd !== 32'h0) begin failures++; $display("FAIL ovf_b_bcd: got %h required 0", bcd); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_b_flag: got %b required 1", overflow); end
        checks++; if (hex !== {8{7'h40}}) begin failures++; $display("FAIL ovf_b_hex: got %h required all 40", hex); end
        @(negedge clk); value = 32'hFFFFFFFF;
        wait_done("ovf_c");
        checks++; if (bcd !== 32'h94967295) begin failures++; $display("FAIL ovf_c_bcd: got %h required 94967295", bcd); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_c_flag: got %b required 1", overflow); end
        checks++;
        if (hex !== {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}) begin
            failures++; $display("FAIL ovf_c_hex: got %h required 10,19,10,02,78,24,10,12", hex);
        end
    endtask

    task automatic test_back_to_back;
        logic extra;
        @(negedge clk); value = 32'd5;
        @(posedge clk);
        repeat (5) @(negedge clk);
        value = 32'd7;
        repeat (5) @(negedge clk);
        value = 32'd9;
        wait_done("b2b_a");
        checks++; if (bcd !== 32'h5) begin failures++; $display("FAIL b2b_first: got %h required 5", bcd); end
        wait_done("b2b_b");
        checks++; if (bcd !== 32'h9) begin failures++; $display("FAIL b2b_second: got %h required 9", bcd); end
        extra = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || bcd !== 32'h9) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin failures++; $display("FAIL b2b_no_third: got %b required 0", extra); end
    endtask

    task automatic test_reset_mid;
        logic [55:0] hx;
`ifdef BCD_LZ_BLANK_EN
        hx = {{6{7'h7F}}, 7'h19, 7'h24};
`else
        hx = {{6{7'h40}}, 7'h19, 7'h24};
`endif
        @(negedge clk); value = 32'd42;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b required 0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b required 0", busy); end
        checks++; if (bcd !== 32'h0) begin failures++; $display("FAIL mid_bcd: got %h required 0", bcd); end
        checks++; if (hex !== {56{1'b1}}) begin failures++; $display("FAIL mid_hex: got %h required all 7F", hex); end
        @(negedge clk); rst = 1'b1;
        wait_done("mid_conv");
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mid_valid2: got %b required 1", valid); end
        checks++; if (bcd !== 32'h42) begin failures++; $display("FAIL mid_bcd2: got %h required 00000042", bcd); end
        checks++; if (hex !== hx) begin failures++; $display("FAIL mid_hex2: got %h required %h", hex, hx); end
    endtask

    task automatic test_steady;
        logic bad;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b1 || bcd !== 32'h42) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL steady: got %b required 0", bad); end
    endtask

    initial begin
        test_reset;
        test_1234;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_steady;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
